ifetch_stage: RTL and testbench
===============================

Name: ifetch_stage

Overview:
- PC generator and IF/ID pipeline register, sitting directly upstream of the instruction memory.
- Drives curr_pc into the combinational instruction memory and captures the returned instruction word into IF/ID registers for the decoder.
- Handles decode stalls, branch/jump redirects (flush), misaligned redirect traps, and keeps a retired-fetch counter.

Parameters:
- CPU_WIDTH, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value after reset (must be 4-byte aligned).
- NOP_INST, 32'h0000_0013, bubble inserted on flush/reset (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset: synchronous, active-low.
- stall  input  1  decode/hazard stall; hold PC and IF/ID contents.
- redirect_valid  input  1  taken branch/jump this cycle.
- redirect_target  input  CPU_WIDTH  new PC when redirect_valid=1.
- instruction  input  CPU_WIDTH  word returned by imem for curr_pc (combinational, same cycle).
- curr_pc  output  CPU_WIDTH  fetch address to imem (= internal pc register).
- id_valid  output  1  IF/ID holds a real instruction.
- id_pc  output  CPU_WIDTH  PC of id_inst.
- id_pc_plus4  output  CPU_WIDTH  id_pc+4, for jal/jalr link.
- id_inst  output  CPU_WIDTH  captured instruction.
- fetch_misalign  output  1  sticky trap flag: redirect target not 4-byte aligned.
- trap_pc  output  CPU_WIDTH  offending redirect_target.
- fetch_cnt  output  CPU_WIDTH  number of instructions captured into IF/ID.

Behaviour:
- All state updates on posedge clk. rst_n=0 at an edge overrides everything, including mid-stall, mid-redirect and trap.
- Reset values:
  - pc=RESET_PC, id_valid=0, id_pc=0, id_pc_plus4=4, id_inst=NOP_INST.
  - fetch_misalign=0, trap_pc=0, fetch_cnt=0, state=S_BOOT.
- FSM states: S_BOOT, S_RUN, S_TRAP.
  - S_BOOT: a single cycle after reset release. pc holds RESET_PC, no capture, id_valid=0; next state is S_RUN. This gives imem its load cycle.
  - S_RUN: per-cycle priority is reset > redirect > stall > advance.
    - redirect_valid=1, target[1:0]==0: pc<=target; id_valid<=0; id_inst<=NOP_INST; id_pc/id_pc_plus4 hold. The in-flight fetch is discarded and fetch_cnt is unchanged. Redirect wins over a simultaneous stall.
    - redirect_valid=1, target[1:0]!=0: fetch_misalign<=1; trap_pc<=target; id_valid<=0; id_inst<=NOP_INST; pc holds; next state is S_TRAP.
    - stall=1 (no redirect): pc, id_* and fetch_cnt all hold.
    - advance: id_pc<=pc; id_pc_plus4<=pc+4; id_inst<=instruction; id_valid<=1; pc<=pc+4; fetch_cnt<=fetch_cnt+1.
  - S_TRAP: absorbing until reset. pc holds, id_valid=0, id_inst=NOP_INST, and fetch_misalign/trap_pc hold. Stall and redirect are ignored.
- Arithmetic: pc+4 and fetch_cnt wrap modulo 2^CPU_WIDTH with no overflow flag. 32'hFFFF_FFFC advances to 0.
- Latency: the instruction at PC p appears on id_inst one edge after curr_pc=p, provided there is no stall or redirect.
- curr_pc is a direct register output with no combinational path from the inputs.

Test Plan:
- Reset then free run, with imem loaded with 0x00000013, 0x00600493, 0x00500513:
  - Cycle after reset: curr_pc=0, id_valid=0.
  - Next edge: id_inst=0x00000013, id_pc=0.
  - Then id_inst=0x00600493, id_pc=4, id_pc_plus4=8; fetch_cnt increments 1, 2, 3.
- Stall held 3 cycles while id_pc=8:
  - curr_pc stays 0xC and id_* stay frozen for those 3 cycles.
  - fetch_cnt is unchanged.
  - On release, id_pc=0xC on the next edge.
- Redirect to 0x10 together with stall=1 at curr_pc=0x1C:
  - Next edge: curr_pc=0x10, id_valid=0, id_inst=0x00000013.
  - Following edge: id_pc=0x10, id_valid=1.
- Redirect to 0x16 (misaligned):
  - Next edge: fetch_misalign=1, trap_pc=0x16, id_valid=0, curr_pc frozen.
  - A later redirect to 0x20 is ignored.
- rst_n=0 for one edge during S_TRAP and mid-stall:
  - Every output returns to its reset value (curr_pc=RESET_PC, fetch_misalign=0, fetch_cnt=0).
  - S_BOOT is repeated.
- Wrap: with RESET_PC=0xFFFF_FFFC, run 2 fetches:
  - id_pc=0xFFFF_FFFC, id_pc_plus4=0.
  - Next id_pc=0.

Source files
------------

// File: rtl/ifetch_stage_if.sv
// Fetch-stage bus: decode-side controls, imem address/data and the IF/ID register outputs.
// master = fetch stage, slave = surrounding pipeline / instruction memory.
interface ifetch_stage_if #(
  parameter int unsigned CPU_WIDTH = 32
);
  logic                 stall;
  logic                 redirect_valid;
  logic [CPU_WIDTH-1:0] redirect_target;
  logic [CPU_WIDTH-1:0] instruction;
  logic [CPU_WIDTH-1:0] curr_pc;
  logic                 id_valid;
  logic [CPU_WIDTH-1:0] id_pc;
  logic [CPU_WIDTH-1:0] id_pc_plus4;
  logic [CPU_WIDTH-1:0] id_inst;
  logic                 fetch_misalign;
  logic [CPU_WIDTH-1:0] trap_pc;
  logic [CPU_WIDTH-1:0] fetch_cnt;

  modport master (
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    input  instruction,
    output curr_pc,
    output id_valid,
    output id_pc,
    output id_pc_plus4,
    output id_inst,
    output fetch_misalign,
    output trap_pc,
    output fetch_cnt
  );

  modport slave (
    output stall,
    output redirect_valid,
    output redirect_target,
    output instruction,
    input  curr_pc,
    input  id_valid,
    input  id_pc,
    input  id_pc_plus4,
    input  id_inst,
    input  fetch_misalign,
    input  trap_pc,
    input  fetch_cnt
  );
endinterface

// File: rtl/ifetch_stage.sv
// PC generator plus IF/ID pipeline register with stall, redirect/flush,
// misaligned-redirect trap and a count of instructions captured into IF/ID.
module ifetch_stage #(
  parameter int unsigned          CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [CPU_WIDTH-1:0] NOP_INST  = CPU_WIDTH'(32'h0000_0013)
) (
  input logic           clk,
  input logic           rst_n,
  ifetch_stage_if.master bus
);

  localparam logic [CPU_WIDTH-1:0] PcStep = CPU_WIDTH'(4);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StTrap
  } state_e;

  state_e               state_q;
  logic [CPU_WIDTH-1:0] pc_q;
  logic                 id_valid_q;
  logic [CPU_WIDTH-1:0] id_pc_q;
  logic [CPU_WIDTH-1:0] id_pc_plus4_q;
  logic [CPU_WIDTH-1:0] id_inst_q;
  logic                 fetch_misalign_q;
  logic [CPU_WIDTH-1:0] trap_pc_q;
  logic [CPU_WIDTH-1:0] fetch_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= StBoot;
      pc_q             <= RESET_PC;
      id_valid_q       <= 1'b0;
      id_pc_q          <= '0;
      id_pc_plus4_q    <= PcStep;
      id_inst_q        <= NOP_INST;
      fetch_misalign_q <= 1'b0;
      trap_pc_q        <= '0;
      fetch_cnt_q      <= '0;
    end else begin
      unique case (state_q)
        // One idle cycle so imem sees RESET_PC before the first capture.
        StBoot: begin
          id_valid_q <= 1'b0;
          state_q    <= StRun;
        end

        StRun: begin
          if (bus.redirect_valid) begin
            id_valid_q <= 1'b0;
            id_inst_q  <= NOP_INST;
            if (bus.redirect_target[1:0] == 2'b00) begin
              pc_q <= bus.redirect_target;
            end else begin
              fetch_misalign_q <= 1'b1;
              trap_pc_q        <= bus.redirect_target;
              state_q          <= StTrap;
            end
          end else if (!bus.stall) begin
            id_pc_q       <= pc_q;
            id_pc_plus4_q <= pc_q + PcStep;
            id_inst_q     <= bus.instruction;
            id_valid_q    <= 1'b1;
            pc_q          <= pc_q + PcStep;
            fetch_cnt_q   <= fetch_cnt_q + CPU_WIDTH'(1);
          end
        end

        // Absorbing: only reset leaves this state.
        StTrap: begin
          id_valid_q <= 1'b0;
          id_inst_q  <= NOP_INST;
        end

        default: state_q <= StBoot;
      endcase
    end
  end

  assign bus.curr_pc        = pc_q;
  assign bus.id_valid       = id_valid_q;
  assign bus.id_pc          = id_pc_q;
  assign bus.id_pc_plus4    = id_pc_plus4_q;
  assign bus.id_inst        = id_inst_q;
  assign bus.fetch_misalign = fetch_misalign_q;
  assign bus.trap_pc        = trap_pc_q;
  assign bus.fetch_cnt      = fetch_cnt_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: free run, stall, redirect, misaligned trap, reset, PC wrap.
module tb_ifetch_stage;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] Nop = 32'h0000_0013;

  logic clk;
  logic rst_n;
  logic rst2_n;

  int unsigned n_checks;
  int unsigned n_fail;

  ifetch_stage_if #(.CPU_WIDTH(W)) bus  ();
  ifetch_stage_if #(.CPU_WIDTH(W)) bus2 ();

  ifetch_stage #(
    .CPU_WIDTH(W),
    .RESET_PC (32'h0000_0000),
    .NOP_INST (Nop)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  ifetch_stage #(
    .CPU_WIDTH(W),
    .RESET_PC (32'hFFFF_FFFC),
    .NOP_INST (Nop)
  ) u_dut_wrap (
    .clk  (clk),
    .rst_n(rst2_n),
    .bus  (bus2)
  );

  // Words 0..2 are the loaded program; every other word encodes its own address.
  function automatic logic [W-1:0] imem_read(input logic [W-1:0] addr);
    unique case (addr[7:2])
      6'd0:    imem_read = 32'h0000_0013;
      6'd1:    imem_read = 32'h0060_0493;
      6'd2:    imem_read = 32'h0050_0513;
      default: imem_read = {16'hA5A5, addr[15:0]};
    endcase
  endfunction

  assign bus.instruction  = imem_read(bus.curr_pc);
  assign bus2.instruction = imem_read(bus2.curr_pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic [W-1:0] pc, input logic [W-1:0] vld,
                          input logic [W-1:0] id_pc, input logic [W-1:0] inst,
                          input logic [W-1:0] cnt);
    check_eq({tag, ".curr_pc"},   bus.curr_pc,               pc);
    check_eq({tag, ".id_valid"},  W'(bus.id_valid),          vld);
    check_eq({tag, ".id_pc"},     bus.id_pc,                 id_pc);
    check_eq({tag, ".id_pc_p4"},  bus.id_pc_plus4,           id_pc + 32'd4);
    check_eq({tag, ".id_inst"},   bus.id_inst,               inst);
    check_eq({tag, ".fetch_cnt"}, bus.fetch_cnt,             cnt);
  endtask

  task automatic check_reset(input string tag);
    check_id(tag, 32'h0, 32'h0, 32'h0, Nop, 32'h0);
    check_eq({tag, ".misalign"}, W'(bus.fetch_misalign), 32'h0);
    check_eq({tag, ".trap_pc"},  bus.trap_pc,            32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rst2_n   = 1'b0;
    bus.stall            = 1'b0;
    bus.redirect_valid   = 1'b0;
    bus.redirect_target  = '0;
    bus2.stall           = 1'b0;
    bus2.redirect_valid  = 1'b0;
    bus2.redirect_target = '0;

    tick();
    tick();
    check_reset("reset");

    rst_n = 1'b1;
    tick();
    check_id("boot", 32'h0, 32'h0, 32'h0, Nop, 32'h0);

    tick();
    check_id("run0", 32'h4, 32'h1, 32'h0, 32'h0000_0013, 32'h1);
    tick();
    check_id("run1", 32'h8, 32'h1, 32'h4, 32'h0060_0493, 32'h2);
    tick();
    check_id("run2", 32'hC, 32'h1, 32'h8, 32'h0050_0513, 32'h3);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_id("stall", 32'hC, 32'h1, 32'h8, 32'h0050_0513, 32'h3);
    end
    bus.stall = 1'b0;
    tick();
    check_id("unstall", 32'h10, 32'h1, 32'hC, 32'hA5A5_000C, 32'h4);

    tick();
    tick();
    tick();
    check_id("run_to_1c", 32'h1C, 32'h1, 32'h18, 32'hA5A5_0018, 32'h7);

    // Redirect beats a simultaneous stall.
    bus.stall           = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h10;
    tick();
    check_id("redir", 32'h10, 32'h0, 32'h18, Nop, 32'h7);
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    tick();
    check_id("post_redir", 32'h14, 32'h1, 32'h10, 32'hA5A5_0010, 32'h8);

    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h16;
    tick();
    check_id("trap", 32'h14, 32'h0, 32'h10, Nop, 32'h8);
    check_eq("trap.misalign", W'(bus.fetch_misalign), 32'h1);
    check_eq("trap.trap_pc",  bus.trap_pc,            32'h16);

    bus.redirect_target = 32'h20;
    tick();
    check_id("trap_hold", 32'h14, 32'h0, 32'h10, Nop, 32'h8);
    check_eq("trap_hold.misalign", W'(bus.fetch_misalign), 32'h1);
    check_eq("trap_hold.trap_pc",  bus.trap_pc,            32'h16);

    // Reset out of the trap while a stall is also asserted.
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b1;
    rst_n              = 1'b0;
    tick();
    check_reset("rst_trap");
    rst_n     = 1'b1;
    bus.stall = 1'b0;
    tick();
    check_id("reboot", 32'h0, 32'h0, 32'h0, Nop, 32'h0);
    tick();
    check_id("rerun0", 32'h4, 32'h1, 32'h0, 32'h0000_0013, 32'h1);

    bus.stall = 1'b1;
    tick();
    check_id("stall2", 32'h4, 32'h1, 32'h0, 32'h0000_0013, 32'h1);
    rst_n = 1'b0;
    tick();
    check_reset("rst_stall");
    rst_n     = 1'b1;
    bus.stall = 1'b0;
    tick();
    check_id("reboot2", 32'h0, 32'h0, 32'h0, Nop, 32'h0);

    // PC wrap on the second instance.
    tick();
    rst2_n = 1'b1;
    tick();
    check_eq("wrap.boot_pc",   bus2.curr_pc,       32'hFFFF_FFFC);
    check_eq("wrap.boot_vld",  W'(bus2.id_valid),  32'h0);
    tick();
    check_eq("wrap.id_pc",     bus2.id_pc,         32'hFFFF_FFFC);
    check_eq("wrap.id_pc_p4",  bus2.id_pc_plus4,   32'h0);
    check_eq("wrap.id_inst",   bus2.id_inst,       32'hA5A5_FFFC);
    check_eq("wrap.curr_pc",   bus2.curr_pc,       32'h0);
    tick();
    check_eq("wrap2.id_pc",    bus2.id_pc,         32'h0);
    check_eq("wrap2.id_inst",  bus2.id_inst,       32'h0000_0013);
    check_eq("wrap2.cnt",      bus2.fetch_cnt,     32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
